des_key_schedule: RTL

- Upstream neighbour of the DES round control FSM. Takes a 64-bit DES key and generates all 16 48-bit round subkeys into an internal subkey store.
- Generation uses PC-1, the per-round left rotations of C/D, then PC-2.
- Once the store is loaded, the block serves subkey read requests by 4-bit index with one-cycle registered latency.
- The round FSM does its own encrypt/decrypt index reversal (15 - round) before issuing a request.

---
 rtl/des_pkg.sv | 62 ++++++
 rtl/des_rotate_pc2.sv | 19 +
 rtl/des_key_schedule.sv | 109 ++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES tables, sizes and key-schedule state encoding.
// Tables use FIPS 46 numbering: bit 1 is the MSB of the 64-bit key.
package des_pkg;

   localparam int NUM_ROUNDS = 16;
   localparam int SUBKEY_W   = 48;
   localparam int HALF_W     = 28;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GEN   = 2'd1,
      ST_READY = 2'd2
   } des_ks_state_e;

   // Element 0 is the first table entry, i.e. the source of output bit 1.
   localparam logic [0:55][5:0] PC1_TBL = {
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
      6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
      6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
      6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
      6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   localparam logic [0:47][5:0] PC2_TBL = {
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   localparam logic [0:15][1:0] SHIFT_TBL = {
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // Returns {C, D}: C in bits [55:28], D in bits [27:0].
   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] cd;
      cd = '0;
      for (int i = 0; i < 56; i++) begin
         cd[6'(55 - i)] = key[6'(64 - int'(PC1_TBL[i]))];
      end
      return cd;
   endfunction

   function automatic logic [SUBKEY_W-1:0] pc2(input logic [55:0] cd);
      logic [SUBKEY_W-1:0] k;
      k = '0;
      for (int i = 0; i < SUBKEY_W; i++) begin
         k[6'(47 - i)] = cd[6'(56 - int'(PC2_TBL[i]))];
      end
      return k;
   endfunction

endpackage

// File: rtl/des_rotate_pc2.sv
// One key-schedule step: rotate C and D left by 1 or 2, then apply PC-2.
module des_rotate_pc2
   import des_pkg::*;
(
   input  logic [HALF_W-1:0]   c_i,
   input  logic [HALF_W-1:0]   d_i,
   input  logic [1:0]          shift_i,
   output logic [HALF_W-1:0]   c_o,
   output logic [HALF_W-1:0]   d_o,
   output logic [SUBKEY_W-1:0] subkey_o
);

   // The DES schedule only ever shifts by 1 or 2.
   assign c_o = (shift_i == 2'd2) ? {c_i[25:0], c_i[27:26]} : {c_i[26:0], c_i[27]};
   assign d_o = (shift_i == 2'd2) ? {d_i[25:0], d_i[27:26]} : {d_i[26:0], d_i[27]};

   assign subkey_o = pc2({c_o, d_o});

endmodule

// File: rtl/des_key_schedule.sv
// Generates the 16 DES round subkeys into a local store, one per cycle,
// and serves indexed subkey reads with one cycle of registered latency.
module des_key_schedule
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                key_load,
   input  logic [63:0]         key,
   output logic                busy,
   output logic                key_ready,
   input  logic                subkey_req,
   input  logic [3:0]          subkey_index,
   output logic                subkey_valid,
   output logic [SUBKEY_W-1:0] subkey,
   output logic                subkey_miss,
   output des_ks_state_e       state_dbg
);

   logic [55:0]         key_cd;
   logic [HALF_W-1:0]   c_q, d_q;
   logic [HALF_W-1:0]   c_rot, d_rot;
   logic [SUBKEY_W-1:0] rot_subkey;
   logic [3:0]          round_q;
   des_ks_state_e       state_q;
   logic                busy_q, key_ready_q;

   logic [SUBKEY_W-1:0] store_q [NUM_ROUNDS];
   logic [SUBKEY_W-1:0] subkey_q;
   logic                subkey_valid_q, subkey_miss_q;

   assign key_cd = pc1(key);

   des_rotate_pc2 u_rotate_pc2 (
      .c_i      (c_q),
      .d_i      (d_q),
      .shift_i  (SHIFT_TBL[round_q]),
      .c_o      (c_rot),
      .d_o      (d_rot),
      .subkey_o (rot_subkey)
   );

   // key_load wins in every state, so a load during GEN restarts cleanly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         round_q     <= '0;
         c_q         <= '0;
         d_q         <= '0;
         busy_q      <= 1'b0;
         key_ready_q <= 1'b0;
      end else if (key_load) begin
         state_q     <= ST_GEN;
         round_q     <= '0;
         c_q         <= key_cd[55:28];
         d_q         <= key_cd[27:0];
         busy_q      <= 1'b1;
         key_ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_GEN: begin
               c_q     <= c_rot;
               d_q     <= d_rot;
               round_q <= round_q + 4'd1;
               if (round_q == 4'(NUM_ROUNDS - 1)) begin
                  state_q     <= ST_READY;
                  busy_q      <= 1'b0;
                  key_ready_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Store has no reset: key_ready gates every read of it.
   always_ff @(posedge clk) begin
      if (state_q == ST_GEN) begin
         store_q[round_q] <= rot_subkey;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         subkey_q       <= '0;
         subkey_valid_q <= 1'b0;
         subkey_miss_q  <= 1'b0;
      end else begin
         subkey_valid_q <= 1'b0;
         subkey_miss_q  <= 1'b0;
         if (subkey_req) begin
            if (key_ready_q) begin
               subkey_q       <= store_q[subkey_index];
               subkey_valid_q <= 1'b1;
            end else begin
               subkey_miss_q  <= 1'b1;
            end
         end
      end
   end

   assign busy         = busy_q;
   assign key_ready    = key_ready_q;
   assign subkey       = subkey_q;
   assign subkey_valid = subkey_valid_q;
   assign subkey_miss  = subkey_miss_q;
   assign state_dbg    = state_q;

endmodule
